tile_fill: RTL and testbench
============================

# tile_fill

Rectangle fill engine that writes solid-colour tiles into the 80×60 tile framebuffer consumed by the VGA pixel path. It accepts one rectangle command at a time through a valid/ready handshake. It clips the rectangle to the screen and issues one 32-bit word write per tile, at address `y*80 + x`, through a stallable write port. It sits between the drawing/CPU logic and the framebuffer memory's write side.

## Interface

Parameters:

- `TILES_X`, default 80: tiles per row; also the address row stride.
- `TILES_Y`, default 60: tile rows.

Ports:

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: engine can accept a command.
- `cmd_x` in 7: top-left tile column.
- `cmd_y` in 6: top-left tile row.
- `cmd_w` in 7: width in tiles.
- `cmd_h` in 6: height in tiles.
- `cmd_color` in 24: colour, with R in [7:0], G in [15:8], B in [23:16].
- `fb_write` out 1: write request.
- `fb_address` out 32: word address, `y*TILES_X + x`, zero-extended.
- `fb_data_write` out 32: `{8'h00, color}`.
- `fb_wait` in 1: memory stall; the current write has not completed while this is high.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse when a command finishes.

## Operation

- States: IDLE, FILL, DONE.
- IDLE:
  - `cmd_ready`=1.
  - A command is accepted on an edge where `cmd_valid && cmd_ready`.
  - On acceptance, latch x0, y0, and colour, and compute clipped bounds: `x_end = min(cmd_x+cmd_w, TILES_X)` and `y_end = min(cmd_y+cmd_h, TILES_Y)`. Use 8-bit intermediates so the sums cannot overflow.
  - If `cmd_w==0`, `cmd_h==0`, `cmd_x>=TILES_X` or `cmd_y>=TILES_Y`, go to DONE with zero writes. Otherwise go to FILL with cursor (x,y)=(x0,y0).
- FILL:
  - `fb_write`=1, with `fb_address` and `fb_data_write` driven from the cursor.
  - A write completes on an edge where `fb_write && !fb_wait`.
  - On completion:
    - If `x+1 < x_end`, then x++.
    - Else x←x0 and y++.
    - When the completing write is (x_end-1, y_end-1), go to DONE.
  - While `fb_wait`=1, the cursor, address and data hold stable.
- DONE:
  - `done`=1 for exactly one cycle, then return to IDLE.
- Writes occur in raster order: row-major, left to right, top to bottom.
- The number of writes equals `(x_end-x0)*(y_end-y0)`.
- `cmd_*` inputs are ignored outside the acceptance edge.
- Reset mid-operation: state returns to IDLE immediately (asynchronously). The in-flight write is abandoned with no completion, and no `done` is produced.

## Timing

- Reset values: `cmd_ready`=1, `fb_write`=0, `fb_address`=0, `fb_data_write`=0, `busy`=0, `done`=0.
- All outputs are registered or decoded from state only; there is no combinational path from `cmd_*` or `fb_wait` to any output.
- Latency:
  - Acceptance at edge N gives the first `fb_write` in cycle N+1.
  - With no stalls, writes occupy cycles N+1 … N+K, where K is the write count.
  - `done` is asserted in cycle N+K+1.
  - `cmd_ready` returns in cycle N+K+2.
  - Each stall cycle adds one cycle.
- Empty or fully clipped command: accept at N, `done` in cycle N+1, `cmd_ready` again in N+2.
- Back-to-back commands: at least one idle cycle (DONE) separates consecutive commands.

## Configuration

- `TILE_FILL_ABORT_EN`:
  - Defined:
    - Adds input port `abort` (1 bit).
    - In FILL, on an edge where `abort && !fb_wait`, the current write completes and the FSM goes to DONE. `done` pulses normally and no further writes are issued.
    - `abort` is ignored while `fb_wait`=1 and in IDLE and DONE.
  - Undefined: no `abort` port; every command runs to completion.

## Test plan

- Reset:
  - Assert `reset` mid-cycle → outputs take their reset values immediately.
  - Release, then send a command → behaviour is normal.
- Basic fill:
  - Command: x=2, y=3, w=3, h=2, colour 0x332211, `fb_wait`=0.
  - Required: writes to addresses 242, 243, 244, 322, 323, 324, each with data 0x00332211, in consecutive cycles.
  - `done` one cycle after the last write; `cmd_ready` low throughout.
- Clipping:
  - Command: x=78, y=59, w=5, h=4.
  - Required: exactly two writes, at 4798 and 4799, then `done`.
- Empty:
  - Command with w=0 (and separately x=80) → zero `fb_write` cycles, `done` in the cycle after acceptance.
- Stall:
  - Command: x=0, y=0, w=2, h=1, with `fb_wait` held high for 3 cycles during the write to address 1.
  - Required: address 1 and its data stay stable for those 3 cycles; a single completion; `done` 5 cycles after the first write.
- Reset mid-fill / abort:
  - Apply `reset` after 2 of 6 writes → no further writes and no `done`.
  - With `TILE_FILL_ABORT_EN`: pulse `abort` on write 2 with `fb_wait`=0 → exactly 2 writes, then `done`.

Source files
------------

// File: rtl/tile_fill.sv
// tile_fill: clipped solid-colour rectangle fill into the tile framebuffer (optional abort via TILE_FILL_ABORT_EN)
module tile_fill #(
  parameter int TILES_X = 80,
  parameter int TILES_Y = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_x,
  input  logic [5:0]  cmd_y,
  input  logic [6:0]  cmd_w,
  input  logic [5:0]  cmd_h,
  input  logic [23:0] cmd_color,
  output logic        fb_write,
  output logic [31:0] fb_address,
  output logic [31:0] fb_data_write,
  input  logic        fb_wait,
`ifdef TILE_FILL_ABORT_EN
  input  logic        abort,
`endif
  output logic        busy,
  output logic        done
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]  state;
  logic [6:0]  x0, x;
  logic [5:0]  y;
  logic [7:0]  x_end, y_end;
  logic [23:0] color;
  logic [7:0]  sum_x, sum_y;
  logic        empty, x_last, y_last, stop;
`ifdef TILE_FILL_ABORT_EN
  assign stop = abort;
`else
  assign stop = 1'b0;
`endif
  assign sum_x = {1'b0, cmd_x} + {1'b0, cmd_w};
  assign sum_y = {2'b00, cmd_y} + {2'b00, cmd_h};
  assign empty = cmd_w == 7'd0 || cmd_h == 6'd0 || {1'b0, cmd_x} >= 8'(TILES_X) || {2'b00, cmd_y} >= 8'(TILES_Y);
  assign x_last = {1'b0, x} + 8'd1 >= x_end;
  assign y_last = {2'b00, y} + 8'd1 >= y_end;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign fb_write = state == FILL;
  assign fb_address = 32'(y) * 32'(TILES_X) + 32'(x);
  assign fb_data_write = {8'h00, color};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      x0 <= '0;
      x <= '0;
      y <= '0;
      x_end <= '0;
      y_end <= '0;
      color <= '0;
    end else if (state == IDLE) begin
      if (cmd_valid) begin
        x0 <= cmd_x;
        x <= cmd_x;
        y <= cmd_y;
        color <= cmd_color;
        x_end <= sum_x > 8'(TILES_X) ? 8'(TILES_X) : sum_x;
        y_end <= sum_y > 8'(TILES_Y) ? 8'(TILES_Y) : sum_y;
        state <= empty ? DONE : FILL;
      end
    end else if (state == FILL) begin
      if (!fb_wait) begin
        if ((x_last && y_last) || stop) state <= DONE;
        else if (x_last) begin
          x <= x0;
          y <= y + 6'd1;
        end else x <= x + 7'd1;
      end
    end else state <= IDLE;
endmodule

// File: tb/tb_tile_fill.sv
// tb_tile_fill: directed self-checking bench for tile_fill
module tb_tile_fill;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [6:0]  cmd_x = '0;
  logic [5:0]  cmd_y = '0;
  logic [6:0]  cmd_w = '0;
  logic [5:0]  cmd_h = '0;
  logic [23:0] cmd_color = '0;
  logic        fb_write;
  logic [31:0] fb_address;
  logic [31:0] fb_data_write;
  logic        fb_wait = 1'b0;
  logic        busy;
  logic        done;
`ifdef TILE_FILL_ABORT_EN
  logic        abort = 1'b0;
`endif
  int n_checks = 0;
  int n_fail = 0;

  tile_fill dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .fb_write(fb_write), .fb_address(fb_address), .fb_data_write(fb_data_write),
    .fb_wait(fb_wait),
`ifdef TILE_FILL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [6:0] x, input logic [5:0] y, input logic [6:0] w, input logic [5:0] h, input logic [23:0] c);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_x = x;
    cmd_y = y;
    cmd_w = w;
    cmd_h = h;
    cmd_color = c;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_x = 7'd5;
    cmd_y = 6'd5;
    cmd_w = 7'd9;
    cmd_h = 6'd9;
    cmd_color = 24'hFFFFFF;
  endtask

  task automatic test_reset;
    #3 reset = 1'b1;
    #1;
    n_checks++;
    if ({cmd_ready, fb_write, busy, done} !== 4'b1000 || fb_address !== 32'd0 || fb_data_write !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_values: ready/write/busy/done=%b addr=%0d data=%h, required 1000 0 0", {cmd_ready, fb_write, busy, done}, fb_address, fb_data_write);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic;
    logic [31:0] exp_addr [6] = '{32'd242, 32'd243, 32'd244, 32'd322, 32'd323, 32'd324};
    send(7'd2, 6'd3, 7'd3, 6'd2, 24'h332211);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (fb_write !== 1'b1 || fb_address !== exp_addr[i] || fb_data_write !== 32'h00332211 || cmd_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_write%0d: write=%b addr=%0d data=%h ready=%b done=%b, required 1 %0d 00332211 0 0", i, fb_write, fb_address, fb_data_write, cmd_ready, done, exp_addr[i]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (done !== 1'b1 || fb_write !== 1'b0 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: done=%b write=%b ready=%b, required 1 0 0", done, fb_write, cmd_ready);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle: done=%b ready=%b busy=%b, required 0 1 0", done, cmd_ready, busy);
    end
  endtask

  task automatic test_clip;
    send(7'd78, 6'd59, 7'd5, 6'd4, 24'hABCDEF);
    n_checks++;
    if (fb_write !== 1'b1 || fb_address !== 32'd4798 || fb_data_write !== 32'h00ABCDEF) begin
      n_fail++;
      $display("FAIL clip_w0: write=%b addr=%0d data=%h, required 1 4798 00abcdef", fb_write, fb_address, fb_data_write);
    end
    @(negedge clk);
    n_checks++;
    if (fb_write !== 1'b1 || fb_address !== 32'd4799) begin
      n_fail++;
      $display("FAIL clip_w1: write=%b addr=%0d, required 1 4799", fb_write, fb_address);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || fb_write !== 1'b0) begin
      n_fail++;
      $display("FAIL clip_done: done=%b write=%b, required 1 0", done, fb_write);
    end
    @(negedge clk);
  endtask

  task automatic test_empty;
    logic [6:0] ex [2] = '{7'd4, 7'd80};
    logic [6:0] ew [2] = '{7'd0, 7'd3};
    for (int i = 0; i < 2; i++) begin
      send(ex[i], 6'd1, ew[i], 6'd2, 24'h123456);
      n_checks++;
      if (done !== 1'b1 || fb_write !== 1'b0 || cmd_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL empty%0d_done: done=%b write=%b ready=%b, required 1 0 0", i, done, fb_write, cmd_ready);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || fb_write !== 1'b0 || cmd_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL empty%0d_idle: done=%b write=%b ready=%b, required 0 0 1", i, done, fb_write, cmd_ready);
      end
    end
  endtask

  task automatic test_stall;
    send(7'd0, 6'd0, 7'd2, 6'd1, 24'h0000FF);
    n_checks++;
    if (fb_write !== 1'b1 || fb_address !== 32'd0) begin
      n_fail++;
      $display("FAIL stall_w0: write=%b addr=%0d, required 1 0", fb_write, fb_address);
    end
    @(negedge clk);
    fb_wait = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (fb_write !== 1'b1 || fb_address !== 32'd1 || fb_data_write !== 32'h000000FF || done !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold%0d: write=%b addr=%0d data=%h done=%b, required 1 1 000000ff 0", i, fb_write, fb_address, fb_data_write, done);
      end
      @(negedge clk);
      if (i == 2) fb_wait = 1'b0;
    end
    n_checks++;
    if (done !== 1'b1 || fb_write !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_done: done=%b write=%b, required 1 0", done, fb_write);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_fill;
    send(7'd0, 6'd10, 7'd6, 6'd1, 24'h445566);
    n_checks++;
    if (fb_write !== 1'b1 || fb_address !== 32'd800) begin
      n_fail++;
      $display("FAIL midrst_w0: write=%b addr=%0d, required 1 800", fb_write, fb_address);
    end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({cmd_ready, fb_write, busy, done} !== 4'b1000 || fb_address !== 32'd0 || fb_data_write !== 32'd0) begin
      n_fail++;
      $display("FAIL midrst_async: ready/write/busy/done=%b addr=%0d data=%h, required 1000 0 0", {cmd_ready, fb_write, busy, done}, fb_address, fb_data_write);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (fb_write !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_quiet%0d: write=%b done=%b, required 0 0", i, fb_write, done);
      end
      @(negedge clk);
    end
  endtask

`ifdef TILE_FILL_ABORT_EN
  task automatic test_abort;
    send(7'd10, 6'd0, 7'd6, 6'd1, 24'h777777);
    n_checks++;
    if (fb_write !== 1'b1 || fb_address !== 32'd10) begin
      n_fail++;
      $display("FAIL abort_w0: write=%b addr=%0d, required 1 10", fb_write, fb_address);
    end
    @(negedge clk);
    abort = 1'b1;
    n_checks++;
    if (fb_write !== 1'b1 || fb_address !== 32'd11) begin
      n_fail++;
      $display("FAIL abort_w1: write=%b addr=%0d, required 1 11", fb_write, fb_address);
    end
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if (done !== 1'b1 || fb_write !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_done: done=%b write=%b, required 1 0", done, fb_write);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_clip;
    test_empty;
    test_stall;
    test_reset_mid_fill;
`ifdef TILE_FILL_ABORT_EN
    test_abort;
`endif
    test_basic;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
